// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and default width for the restoring divider
package div_pkg;

    localparam int DIV_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/sub_n_bit.sv
// rtl/sub_n_bit.sv - x - y as x + ~y + 1, carry-lookahead in 4-bit groups, carry-out = no borrow
module sub_n_bit #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] diff,
    output logic             cout
);

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;

    assign g = x & ~y;
    assign p = x ^ ~y;

    // Each carry is a two-level sum of products from its group's carry-in;
    // only the group carry-ins chain from one group to the next.
    always_comb begin
        int   base;
        logic term;
        logic pall;
        logic acc;
        base = 0;
        term = 1'b0;
        pall = 1'b0;
        acc  = 1'b0;
        c    = '0;
        c[0] = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            base = (i / 4) * 4;
            pall = 1'b1;
            acc  = 1'b0;
            for (int j = base; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) begin
                    term = term & p[m];
                end
                acc  = acc | term;
                pall = pall & p[j];
            end
            c[i+1] = acc | (pall & c[base]);
        end
    end

    assign diff = p ^ c[WIDTH-1:0];
    assign cout = c[WIDTH];

endmodule

// File: rtl/div_8_bit.sv
// rtl/div_8_bit.sv - multi-cycle restoring unsigned divider, one quotient bit per clock
module div_8_bit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_e state;
    div_state_e state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] q_out;
    logic [WIDTH-1:0] r_out;
    logic             dbz;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] q_next;
    logic             accept;
    logic             accept_zero;
    logic             last_step;
    logic             unused_diff_msb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        done        = 1'b0;
        accept      = 1'b0;
        accept_zero = 1'b0;
        last_step   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (B == '0) begin
                        accept_zero = 1'b1;
                        state_next  = DONE;
                    end else begin
                        accept     = 1'b1;
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    last_step  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The dividend register shifts out its MSB each step and fills with
    // quotient bits from the bottom, so it holds the quotient at the end.
    assign rem_shift = {rem, a_reg[WIDTH-1]};

    sub_n_bit #(
        .WIDTH (WIDTH + 1)
    ) u_sub (
        .x    (rem_shift),
        .y    ({1'b0, b_reg}),
        .diff (diff),
        .cout (ge)
    );

    // A restored remainder is always below the divisor, so WIDTH bits hold it.
    assign rem_next        = ge ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    assign q_next          = {a_reg[WIDTH-2:0], ge};
    assign unused_diff_msb = diff[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            rem   <= '0;
            cnt   <= '0;
            q_out <= '0;
            r_out <= '0;
            dbz   <= 1'b0;
        end else if (accept) begin
            a_reg <= A;
            b_reg <= B;
            rem   <= '0;
            cnt   <= CW'(WIDTH - 1);
            dbz   <= 1'b0;
        end else if (accept_zero) begin
            q_out <= '1;
            r_out <= A;
            dbz   <= 1'b1;
        end else if (busy) begin
            a_reg <= q_next;
            rem   <= rem_next;
            cnt   <= cnt - CW'(1);
            if (last_step) begin
                q_out <= q_next;
                r_out <= rem_next;
            end
        end
    end

    assign Q           = q_out;
    assign R           = r_out;
    assign div_by_zero = dbz;

endmodule

// File: doc/div_8_bit.md
DIV_8_BIT -- requirements
Module: div_8_bit

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 8, giving the operand, quotient and remainder width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a division; sampled only while idle.
REQ-005 The block SHALL have port A, input, WIDTH bits: unsigned dividend.
REQ-006 The block SHALL have port B, input, WIDTH bits: unsigned divisor.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a division is iterating.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking valid results.
REQ-009 The block SHALL have port Q, output, WIDTH bits: quotient.
REQ-010 The block SHALL have port R, output, WIDTH bits: remainder.
REQ-011 The block SHALL have port div_by_zero, output, 1 bit: high with done when B was 0.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-013 In IDLE, start=1 with B!=0 SHALL capture A and B, clear the partial remainder, load the bit counter with WIDTH-1 and go to CALC.
REQ-014 In IDLE, start=1 with B=0 SHALL go directly to DONE with Q=all-ones, R=A and div_by_zero=1.
REQ-015 In CALC, each cycle SHALL perform one restoring step, MSB first: shift the next dividend bit into the partial remainder; if the partial remainder is >= the divisor, subtract the divisor and set that quotient bit to 1, else set it to 0.
REQ-016 The partial remainder SHALL be WIDTH+1 bits wide so that the comparison never overflows.
REQ-017 The >= test SHALL use the no-borrow (carry-out=1) result of the subtractor; no separate comparator is permitted.
REQ-018 CALC SHALL last exactly WIDTH cycles, and the final step SHALL move the FSM to DONE.
REQ-019 DONE SHALL last one cycle with done=1 and then return to IDLE unconditionally.
REQ-020 Latency SHALL be WIDTH cycles for a normal division and 1 cycle for divide-by-zero, measured from the start-sampling edge to the first cycle in which done=1.
REQ-021 busy SHALL be 1 exactly while in CALC.
REQ-022 start SHALL be ignored in CALC and DONE; a start held high through DONE SHALL be accepted in the following IDLE cycle.
REQ-023 Q, R and div_by_zero SHALL hold their values after done until the next accepted start.
REQ-024 On the next accepted start, div_by_zero SHALL be cleared.
REQ-025 Changes on A and B after capture SHALL NOT affect an in-flight division.
REQ-026 Results SHALL satisfy A = Q*B + R with R < B for every B != 0, including A=0 and A<B.

Reset
REQ-027 Assertion of rst SHALL immediately force IDLE, busy=0, done=0, Q=0, R=0, div_by_zero=0 and clear all internal registers, asynchronously to clk.
REQ-028 Assertion of rst during CALC or DONE SHALL abort the operation with no done pulse.
REQ-029 After rst is released, the first accepted start SHALL behave as a fresh division.

Structure
REQ-030 State encoding (IDLE, CALC, DONE) and the WIDTH default SHALL live in a shared package, div_pkg.
REQ-031 The subtraction SHALL be a single sub-module, sub_n_bit (parameter WIDTH+1).
REQ-032 sub_n_bit SHALL compute X + ~Y + 1 with carry-lookahead in 4-bit groups and output the difference and carry-out.
REQ-033 All other logic SHALL reside in div_8_bit.

Verification
REQ-034 Normal division: A=100, B=7, start pulse -> done exactly 8 cycles later, Q=14, R=2, div_by_zero=0, busy high for 8 cycles.
REQ-035 Extremes: A=255, B=1 -> Q=255, R=0. A=3, B=10 -> Q=0, R=3. A=0, B=5 -> Q=0, R=0.
REQ-036 Divide by zero: A=5, B=0 -> done 1 cycle later, Q=255, R=5, div_by_zero=1, busy never high.
REQ-037 Ignored start: start=1 with A=9, B=2 on cycle 3 of a running 200/9 division -> results are Q=22, R=2, followed by one further division giving Q=4, R=1 only if start is still high in IDLE.
REQ-038 Reset mid-operation: rst asserted on cycle 4 of CALC -> all outputs 0 at once, no done pulse; the next division 50/6 gives Q=8, R=2.
REQ-039 Random check: at least 10,000 random A/B pairs, each checked against A = Q*B + R with R < B.
